// File: rtl/countdown_timer_ctrl.sv
// countdown_timer_ctrl: egg-timer controller with an integrated mm:ss countdown.
// Programs seconds then minutes from val_in, runs with pause/resume, and flashes
// an alarm that times out back to IDLE.
// Optional feature macro: TIMER_AUTO_RELOAD_EN -- when defined, start_stop in ALARM
// reloads the last programmed interval and returns to READY; when undefined it
// returns to IDLE at 00:00 and no preset register exists.
module countdown_timer_ctrl #(
   parameter int CLK_PER_SEC       = 50_000_000,
   parameter int MIN_W             = 7,
   parameter int MAX_MIN           = 99,
   parameter int FLASH_HALF_CYC    = 12_500_000,
   parameter int FLASH_TIMEOUT_SEC = 30
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             set,
   input  logic             start_stop,
   input  logic [MIN_W-1:0] val_in,
   output logic [MIN_W-1:0] minutes,
   output logic [5:0]       seconds,
   output logic [2:0]       state,
   output logic             running,
   output logic             flashing,
   output logic             flash_on,
   output logic             done_pulse
);

   localparam int PRE_W = $clog2(CLK_PER_SEC);
   localparam int FL_W  = (FLASH_HALF_CYC > 1) ? $clog2(FLASH_HALF_CYC) : 1;
   localparam int TMO_W = (FLASH_TIMEOUT_SEC > 1) ? $clog2(FLASH_TIMEOUT_SEC) : 1;

   localparam logic [PRE_W-1:0] PRE_LAST  = PRE_W'(CLK_PER_SEC - 1);
   localparam logic [FL_W-1:0]  FL_LAST   = FL_W'(FLASH_HALF_CYC - 1);
   localparam logic [TMO_W-1:0] TMO_LAST  = TMO_W'(FLASH_TIMEOUT_SEC - 1);
   localparam logic [MIN_W-1:0] MIN_CLAMP = MIN_W'(MAX_MIN);

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_SET_SEC = 3'd1,
      S_SET_MIN = 3'd2,
      S_READY   = 3'd3,
      S_RUN     = 3'd4,
      S_PAUSE   = 3'd5,
      S_ALARM   = 3'd6,
      S_ILLEGAL = 3'd7
   } state_t;

   state_t             state_q, state_d;
   logic [MIN_W-1:0]   min_q, min_d;
   logic [5:0]         sec_q, sec_d;
   logic [PRE_W-1:0]   presc_q, presc_d;
   logic [FL_W-1:0]    flash_cnt_q, flash_cnt_d;
   logic               flash_on_q, flash_on_d;
   logic [TMO_W-1:0]   tmo_q, tmo_d;
   logic               done_q, done_d;
   logic               time_zero, time_one, timeout;
`ifdef TIMER_AUTO_RELOAD_EN
   logic [MIN_W-1:0]   preset_min_q, preset_min_d;
   logic [5:0]         preset_sec_q, preset_sec_d;
`endif

   function automatic logic [5:0] clamp_sec(input logic [MIN_W-1:0] v);
      logic [5:0] r;
      if (32'(v) > 32'd59) r = 6'd59;
      else                 r = 6'(v);
      return r;
   endfunction

   function automatic logic [MIN_W-1:0] clamp_min(input logic [MIN_W-1:0] v);
      logic [MIN_W-1:0] r;
      if (v > MIN_CLAMP) r = MIN_CLAMP;
      else               r = v;
      return r;
   endfunction

   // Next-state, countdown, flash and timeout logic.
   always_comb begin
      state_d     = state_q;
      min_d       = min_q;
      sec_d       = sec_q;
      presc_d     = presc_q;
      flash_cnt_d = '0;
      flash_on_d  = 1'b0;
      tmo_d       = tmo_q;
      done_d      = 1'b0;
      timeout     = 1'b0;
`ifdef TIMER_AUTO_RELOAD_EN
      preset_min_d = preset_min_q;
      preset_sec_d = preset_sec_q;
`endif
      time_zero = (min_q == '0) && (sec_q == 6'd0);
      time_one  = (min_q == '0) && (sec_q == 6'd1);

      case (state_q)
         S_IDLE: begin
            if (set) state_d = S_SET_SEC;
         end
         S_SET_SEC: begin
            if (set) begin
               sec_d   = clamp_sec(val_in);
               state_d = S_SET_MIN;
            end
         end
         S_SET_MIN: begin
            if (set) begin
               min_d   = clamp_min(val_in);
`ifdef TIMER_AUTO_RELOAD_EN
               preset_min_d = clamp_min(val_in);
               preset_sec_d = sec_q;
`endif
               state_d = S_READY;
            end
         end
         S_READY: begin
            // start_stop outranks set; a zero interval cannot be started
            if (start_stop) begin
               if (!time_zero) begin
                  state_d = S_RUN;
                  presc_d = '0;
               end
            end else if (set) begin
               state_d = S_SET_SEC;
            end
         end
         S_RUN: begin
            // pausing freezes the prescaler, so a tick due this cycle is skipped
            if (start_stop) begin
               state_d = S_PAUSE;
            end else if (presc_q == PRE_LAST) begin
               presc_d = '0;
               if (time_one) begin
                  sec_d       = 6'd0;
                  state_d     = S_ALARM;
                  flash_on_d  = 1'b1;
                  flash_cnt_d = '0;
                  tmo_d       = '0;
                  done_d      = 1'b1;
               end else if (sec_q != 6'd0) begin
                  sec_d = sec_q - 6'd1;
               end else if (min_q != '0) begin
                  sec_d = 6'd59;
                  min_d = min_q - MIN_W'(1);
               end
            end else begin
               presc_d = presc_q + PRE_W'(1);
            end
         end
         S_PAUSE: begin
            if (start_stop)  state_d = S_RUN;
            else if (set)    state_d = S_SET_SEC;
         end
         S_ALARM: begin
            if (flash_cnt_q == FL_LAST) begin
               flash_on_d  = ~flash_on_q;
               flash_cnt_d = '0;
            end else begin
               flash_on_d  = flash_on_q;
               flash_cnt_d = flash_cnt_q + FL_W'(1);
            end
            // prescaler counts whole seconds spent flashing
            if (presc_q == PRE_LAST) begin
               presc_d = '0;
               if (FLASH_TIMEOUT_SEC != 0) begin
                  if (tmo_q == TMO_LAST) timeout = 1'b1;
                  else                   tmo_d   = tmo_q + TMO_W'(1);
               end
            end else begin
               presc_d = presc_q + PRE_W'(1);
            end
            if (start_stop) begin
`ifdef TIMER_AUTO_RELOAD_EN
               state_d = S_READY;
               min_d   = preset_min_q;
               sec_d   = preset_sec_q;
`else
               state_d = S_IDLE;
               min_d   = '0;
               sec_d   = 6'd0;
`endif
            end else if (set) begin
               state_d = S_SET_SEC;
            end else if (timeout) begin
               state_d = S_IDLE;
               min_d   = '0;
               sec_d   = 6'd0;
            end
            if (state_d != S_ALARM) begin
               flash_on_d  = 1'b0;
               flash_cnt_d = '0;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // State and datapath registers with asynchronous clear.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= S_IDLE;
         min_q       <= '0;
         sec_q       <= 6'd0;
         presc_q     <= '0;
         flash_cnt_q <= '0;
         flash_on_q  <= 1'b0;
         tmo_q       <= '0;
         done_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         min_q       <= min_d;
         sec_q       <= sec_d;
         presc_q     <= presc_d;
         flash_cnt_q <= flash_cnt_d;
         flash_on_q  <= flash_on_d;
         tmo_q       <= tmo_d;
         done_q      <= done_d;
      end
   end

`ifdef TIMER_AUTO_RELOAD_EN
   // Preset register holding the last programmed interval.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         preset_min_q <= '0;
         preset_sec_q <= 6'd0;
      end else begin
         preset_min_q <= preset_min_d;
         preset_sec_q <= preset_sec_d;
      end
   end
`endif

   assign minutes    = min_q;
   assign seconds    = sec_q;
   assign state      = state_q;
   assign running    = (state_q == S_RUN);
   assign flashing   = (state_q == S_ALARM);
   assign flash_on   = flash_on_q;
   assign done_pulse = done_q;

endmodule

// File: tb/tb_countdown_timer_ctrl.sv
// tb_countdown_timer_ctrl: directed and random stimulus against a seconds-based
// reference model; expected outputs queue up per cycle and a monitor compares them.
module tb_countdown_timer_ctrl;
   localparam int CPS   = 4;
   localparam int MIN_W = 7;
   localparam int MAXM  = 99;
   localparam int HALF  = 2;
   localparam int TMO   = 3;

   localparam int IDLE = 0, SETSEC = 1, SETMIN = 2, READY = 3, RUN = 4, PAUSE = 5, ALARM = 6;

   logic             clk = 1'b0;
   logic             reset = 1'b1;
   logic             set = 1'b0;
   logic             start_stop = 1'b0;
   logic [MIN_W-1:0] val_in = '0;
   logic [MIN_W-1:0] minutes;
   logic [5:0]       seconds;
   logic [2:0]       state;
   logic             running, flashing, flash_on, done_pulse;

   countdown_timer_ctrl #(
      .CLK_PER_SEC(CPS), .MIN_W(MIN_W), .MAX_MIN(MAXM),
      .FLASH_HALF_CYC(HALF), .FLASH_TIMEOUT_SEC(TMO)
   ) dut (
      .clk(clk), .reset(reset), .set(set), .start_stop(start_stop), .val_in(val_in),
      .minutes(minutes), .seconds(seconds), .state(state), .running(running),
      .flashing(flashing), .flash_on(flash_on), .done_pulse(done_pulse)
   );

   always #5 clk = ~clk;

   typedef struct {
      int st;
      int mm;
      int sec;
      bit run;
      bit fl;
      bit fon;
      bit done;
   } exp_t;

   exp_t sb[$];
   int   checks = 0;
   int   errors = 0;

   // reference model: time held as total seconds, alarm tracked by cycles since entry
   int ms, mt, mpre, ma, mpreset;

   function automatic exp_t model_out();
      exp_t e;
      e.st   = ms;
      e.mm   = mt / 60;
      e.sec  = mt % 60;
      e.run  = (ms == RUN);
      e.fl   = (ms == ALARM);
      e.fon  = (ms == ALARM) && (((ma / HALF) % 2) == 0);
      e.done = (ms == ALARM) && (ma == 0);
      return e;
   endfunction

   task automatic model_reset();
      ms = IDLE; mt = 0; mpre = 0; ma = 0; mpreset = 0;
   endtask

   task automatic model_step(input bit s, input bit ss, input int v);
      case (ms)
         IDLE:   if (s) ms = SETSEC;
         SETSEC: if (s) begin
                    mt = (mt / 60) * 60 + ((v > 59) ? 59 : v);
                    ms = SETMIN;
                 end
         SETMIN: if (s) begin
                    mt = ((v > MAXM) ? MAXM : v) * 60 + (mt % 60);
                    mpreset = mt;
                    ms = READY;
                 end
         READY: begin
            if (ss) begin
               if (mt != 0) begin ms = RUN; mpre = 0; end
            end else if (s) ms = SETSEC;
         end
         RUN: begin
            if (ss) ms = PAUSE;
            else begin
               mpre++;
               if (mpre == CPS) begin
                  mpre = 0;
                  if (mt > 0) mt--;
                  if (mt == 0) begin ms = ALARM; ma = 0; end
               end
            end
         end
         PAUSE: begin
            if (ss) ms = RUN;
            else if (s) ms = SETSEC;
         end
         ALARM: begin
            if (ss) begin
`ifdef TIMER_AUTO_RELOAD_EN
               mt = mpreset; ms = READY;
`else
               mt = 0; ms = IDLE;
`endif
            end else if (s) ms = SETSEC;
            else begin
               ma++;
               if (TMO != 0 && ma == TMO * CPS) begin ms = IDLE; mt = 0; end
            end
         end
         default: ms = IDLE;
      endcase
   endtask

   task automatic check(input string name, input int act, input int req);
      checks++;
      if (act != req) begin
         errors++;
         $display("FAIL %s actual=%0d required=%0d t=%0t", name, act, req, $time);
      end
   endtask

   // monitor: one expected snapshot per clock, compared on the falling edge
   initial begin
      forever begin
         @(negedge clk);
         if (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            check("state",      int'(state),      e.st);
            check("minutes",    int'(minutes),    e.mm);
            check("seconds",    int'(seconds),    e.sec);
            check("running",    int'(running),    int'(e.run));
            check("flashing",   int'(flashing),   int'(e.fl));
            check("flash_on",   int'(flash_on),   int'(e.fon));
            check("done_pulse", int'(done_pulse), int'(e.done));
         end
      end
   end

   task automatic cycle(input bit s, input bit ss, input int v);
      set = s; start_stop = ss; val_in = MIN_W'(v);
      @(posedge clk);
      if (reset) model_reset();
      else       model_step(s, ss, v);
      sb.push_back(model_out());
      #1;
      set = 1'b0; start_stop = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) cycle(1'b0, 1'b0, 0);
   endtask

   // reach SET_SEC from wherever the model is, then program seconds and minutes
   task automatic program_time(input int sv, input int mv);
      for (int i = 0; i < 4 && ms != SETSEC; i++) begin
         if (ms == RUN) cycle(1'b0, 1'b1, 0);
         else           cycle(1'b1, 1'b0, 0);
      end
      cycle(1'b1, 1'b0, sv);
      cycle(1'b1, 1'b0, mv);
   endtask

   // asynchronous reset between edges: outputs must clear before the next edge
   task automatic pulse_reset();
      reset = 1'b1;
      model_reset();
      if (sb.size() > 0) void'(sb.pop_back());
      sb.push_back(model_out());
      idle(2);
      reset = 1'b0;
   endtask

   initial begin
      bit s, ss;
      int v;
      model_reset();
      idle(3);
      reset = 1'b0;

      // clamping: seconds 75 -> 59, minutes 120 -> 99
      program_time(75, 120);
      idle(2);

      // 00:00 in READY cannot start
      program_time(0, 0);
      cycle(1'b0, 1'b1, 0);
      idle(2);

      // 00:02 countdown into ALARM, then the timeout back to IDLE
      program_time(2, 0);
      cycle(1'b0, 1'b1, 0);
      idle(8 + 14);

      // acknowledge the alarm with start_stop
      program_time(2, 0);
      cycle(1'b0, 1'b1, 0);
      idle(10);
      cycle(1'b0, 1'b1, 0);
      idle(3);

      // minute borrow, pause, hold, resume
      program_time(0, 1);
      cycle(1'b0, 1'b1, 0);
      idle(6);
      cycle(1'b0, 1'b1, 0);
      idle(10);
      cycle(1'b0, 1'b1, 0);
      idle(4);

      // set together with start_stop while running only pauses
      cycle(1'b1, 1'b1, 0);
      idle(3);
      cycle(1'b0, 1'b1, 0);
      idle(5);

      // reset while running
      pulse_reset();
      idle(3);

      // random traffic with small values so countdowns complete
      for (int i = 0; i < 4000; i++) begin
         s  = ($urandom_range(0, 15) == 0);
         ss = ($urandom_range(0, 15) == 0);
         v  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 127)) : int'($urandom_range(0, 2));
         if ($urandom_range(0, 499) == 0) pulse_reset();
         else                             cycle(s, ss, v);
      end

      idle(2);
      for (int i = 0; i < 10 && sb.size() > 0; i++) @(negedge clk);
      #1;
      if (sb.size() != 0) begin
         checks++;
         errors++;
         $display("FAIL drain actual=%0d required=0", sb.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
